clk_div_multi: RTL and testbench

Parametrised multi-channel clock divider and tick generator. It is the successor to the board's single fixed 25 M-count divider that produces the slow display/debug clock. Each of NUM_CH channels divides `clk` by a runtime-programmable half-period and produces a 50 %-duty divided clock plus a one-cycle tick at every toggle. Ratio changes are applied glitch-free at the terminal count, and all channels can be phase-aligned with a single sync pulse.

---
 rtl/clk_div_multi.sv | 102 ++++++++++
 tb/tb_clk_div_multi.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// ============================================================================
//  Module      : clk_div_multi
//  Description : Multi-channel programmable clock divider / tick generator.
//                Each channel produces a 50 % duty divided clock and a
//                one-cycle tick on every toggle. New half-periods are staged
//                in a shadow register while running and take effect at the
//                terminal count. A sync pulse realigns all channels.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_multi #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 32,
  parameter int DEFAULT_HALF = 25_000_000,
  parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_data,
  output logic [NUM_CH-1:0] clock_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  localparam logic [CNT_W-1:0] C_DEFAULT_HALF = CNT_W'(DEFAULT_HALF);

  // Writes addressed beyond the last channel are dropped here.
  logic w_wr_valid;
  assign w_wr_valid = wr_en && (int'(wr_ch) < NUM_CH);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pend;
    logic             r_out;
    logic             r_tick;
    logic             w_hit;
    logic             w_term;

    assign w_hit  = w_wr_valid && (wr_ch == CH_W'(gi));
    // >= rather than == so a half that shrank below cnt still terminates.
    assign w_term = (r_cnt >= (r_half - CNT_W'(1)));

    // Channel counter, toggle output, tick and half-period staging.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt    <= '0;
        r_half   <= C_DEFAULT_HALF;
        r_shadow <= '0;
        r_pend   <= 1'b0;
        r_out    <= 1'b0;
        r_tick   <= 1'b0;
      end else if (sync || !en[gi]) begin
        // Realign / idle: restart from zero, adopt any new value right away.
        r_cnt  <= '0;
        r_out  <= 1'b0;
        r_tick <= 1'b0;
        if (w_hit) begin
          r_half <= wr_data;
          r_pend <= 1'b0;
        end else if (r_pend) begin
          r_half <= r_shadow;
          r_pend <= 1'b0;
        end
      end else begin
        r_tick <= 1'b0;
        if (r_half == '0) begin
          // Halted: output frozen, counter parked.
          r_cnt <= '0;
        end else if (w_term) begin
          r_cnt  <= '0;
          r_out  <= ~r_out;
          r_tick <= 1'b1;
          if (r_pend) begin
            r_half <= r_shadow;
            r_pend <= 1'b0;
          end
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        // A write on the terminal edge is staged after the old shadow is used.
        if (w_hit) begin
          r_shadow <= wr_data;
          r_pend   <= 1'b1;
        end
      end
    end

    assign clock_out[gi] = r_out;
    assign tick[gi]      = r_tick;
    assign pending[gi]   = r_pend;
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
// ============================================================================
//  Module      : tb_clk_div_multi
//  Description : Self-checking bench for clk_div_multi with a behavioural
//                per-channel model (cycles-since-toggle view) and randomized
//                stimulus, plus literal timing expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_multi;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int DH     = 4;

  logic              clk     = 1'b0;
  logic              reset   = 1'b1;
  logic [NUM_CH-1:0] en      = '0;
  logic              sync    = 1'b0;
  logic              wr_en   = 1'b0;
  logic [0:0]        wr_ch   = '0;
  logic [CNT_W-1:0]  wr_data = '0;
  logic [NUM_CH-1:0] clock_out, tick, pending;

  // Three-channel instance used to exercise an unmapped channel address.
  logic [2:0]        en3      = '0;
  logic              sync3    = 1'b0;
  logic              wr_en3   = 1'b0;
  logic [1:0]        wr_ch3   = '0;
  logic [CNT_W-1:0]  wr_data3 = '0;
  logic [2:0]        clock_out3, tick3, pending3;

  int total = 0;
  int bad   = 0;

  // Model: each channel tracks its cycles since the last restart/toggle.
  int m_half[NUM_CH];
  int m_shadow[NUM_CH];
  int m_age[NUM_CH];
  bit m_pend[NUM_CH];
  bit m_out[NUM_CH];
  bit m_tk[NUM_CH];

  clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_HALF(DH)) u_dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_data(wr_data), .clock_out(clock_out), .tick(tick),
    .pending(pending)
  );

  clk_div_multi #(.NUM_CH(3), .CNT_W(CNT_W), .DEFAULT_HALF(DH)) u_dut3 (
    .clk(clk), .reset(reset), .en(en3), .sync(sync3), .wr_en(wr_en3),
    .wr_ch(wr_ch3), .wr_data(wr_data3), .clock_out(clock_out3), .tick(tick3),
    .pending(pending3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_half[ch] = DH; m_shadow[ch] = 0; m_age[ch] = 0;
      m_pend[ch] = 0;  m_out[ch] = 0;    m_tk[ch] = 0;
    end
  endfunction

  function automatic void model_step();
    bit hit;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      hit = wr_en && (int'(wr_ch) == ch);
      if (sync || !en[ch]) begin
        m_age[ch] = 0; m_out[ch] = 0; m_tk[ch] = 0;
        if (hit) begin
          m_half[ch] = int'(wr_data); m_pend[ch] = 0;
        end else if (m_pend[ch]) begin
          m_half[ch] = m_shadow[ch]; m_pend[ch] = 0;
        end
      end else begin
        m_tk[ch] = 0;
        if (m_half[ch] == 0) begin
          m_age[ch] = 0;
        end else begin
          m_age[ch] = m_age[ch] + 1;
          if (m_age[ch] >= m_half[ch]) begin
            m_age[ch] = 0;
            m_out[ch] = !m_out[ch];
            m_tk[ch]  = 1;
            if (m_pend[ch]) begin
              m_half[ch] = m_shadow[ch]; m_pend[ch] = 0;
            end
          end
        end
        if (hit) begin
          m_shadow[ch] = int'(wr_data); m_pend[ch] = 1;
        end
      end
    end
  endfunction

  // Model advances on every rising edge outside reset.
  always @(posedge clk) begin
    if (!reset) model_step();
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        chk($sformatf("clock_out[%0d]", ch), int'(clock_out[ch]), int'(m_out[ch]));
        chk($sformatf("tick[%0d]", ch),      int'(tick[ch]),      int'(m_tk[ch]));
        chk($sformatf("pending[%0d]", ch),   int'(pending[ch]),   int'(m_pend[ch]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // After reset release with both channels enabled at half=4.
  task automatic check_basic();
    logic [7:0] exp_out;
    logic [7:0] exp_tick;
    exp_out  = 8'b01111000;
    exp_tick = 8'b10001000;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      chk($sformatf("basic out0 e%0d", k),  int'(clock_out[0]), int'(exp_out[k-1]));
      chk($sformatf("basic out1 e%0d", k),  int'(clock_out[1]), int'(exp_out[k-1]));
      chk($sformatf("basic tick0 e%0d", k), int'(tick[0]),      int'(exp_tick[k-1]));
      chk($sformatf("basic tick1 e%0d", k), int'(tick[1]),      int'(exp_tick[k-1]));
    end
  endtask

  initial begin
    logic a;
    bit   found;
    model_reset();
    cyc(2);
    chk("reset clock_out", int'(clock_out), 0);
    chk("reset tick",      int'(tick),      0);
    chk("reset pending",   int'(pending),   0);
    en    = 2'b11;
    reset = 1'b0;
    check_basic();

    // Running write to ch0.
    wr_en = 1'b1; wr_ch = 1'b0; wr_data = 8'd2;
    cyc(1);
    wr_en = 1'b0;
    chk("run write pending0", int'(pending[0]), 1);
    cyc(12);

    // Out-of-range address on the three-channel instance.
    wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_data3 = 8'd1;
    cyc(1);
    wr_en3 = 1'b0;
    chk("oor pending3", int'(pending3), 0);
    en3 = 3'b111;
    cyc(3);
    chk("oor out3 e3", int'(clock_out3), 0);
    cyc(1);
    chk("oor out3 e4", int'(clock_out3), 7);
    en3 = 3'b000;

    // Disabled write to ch1 applies directly.
    en = 2'b01;
    cyc(1);
    wr_en = 1'b1; wr_ch = 1'b1; wr_data = 8'd1;
    cyc(1);
    wr_en = 1'b0;
    chk("dis write pending1", int'(pending[1]), 0);
    chk("dis write out1",     int'(clock_out[1]), 0);
    en = 2'b11;
    cyc(1);
    a = clock_out[1];
    cyc(1);
    chk("half1 toggles each cycle", int'(clock_out[1]), int'(!a));
    cyc(4);

    // Sync alignment with half 3 / 5.
    wr_en = 1'b1; wr_ch = 1'b0; wr_data = 8'd3;
    cyc(1);
    wr_ch = 1'b1; wr_data = 8'd5;
    cyc(1);
    wr_en = 1'b0;
    cyc(25);
    sync = 1'b1;
    cyc(1);
    sync = 1'b0;
    chk("sync out",  int'(clock_out), 0);
    chk("sync tick", int'(tick), 0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      if (k == 2) chk("sync out0 e2", int'(clock_out[0]), 0);
      if (k == 3) chk("sync out0 e3", int'(clock_out[0]), 1);
      if (k == 3) chk("sync tick0 e3", int'(tick[0]), 1);
      if (k == 4) chk("sync out1 e4", int'(clock_out[1]), 0);
      if (k == 5) chk("sync out1 e5", int'(clock_out[1]), 1);
      if (k == 5) chk("sync tick1 e5", int'(tick[1]), 1);
    end

    // Sync and write on the same edge.
    sync = 1'b1; wr_en = 1'b1; wr_ch = 1'b0; wr_data = 8'd6;
    cyc(1);
    sync = 1'b0; wr_en = 1'b0;
    chk("sync+wr pending0", int'(pending[0]), 0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      if (k == 5) chk("sync+wr out0 e5", int'(clock_out[0]), 0);
      if (k == 6) chk("sync+wr out0 e6", int'(clock_out[0]), 1);
    end

    // Write landing on a terminal-count edge.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_half[0] > 0 && m_age[0] + 1 >= m_half[0]) found = 1;
      else cyc(1);
    end
    chk("term edge found", int'(found), 1);
    wr_en = 1'b1; wr_ch = 1'b0; wr_data = 8'd2;
    cyc(1);
    wr_en = 1'b0;
    chk("term wr tick0",    int'(tick[0]),    1);
    chk("term wr pending0", int'(pending[0]), 1);
    cyc(10);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_ch   = 1'($urandom);
      wr_data = 8'($urandom_range(0, 6));
      sync    = ($urandom_range(0, 24) == 0);
      cyc(1);
    end
    en = 2'b11; wr_en = 1'b0; sync = 1'b0;

    // Restore a known half on ch0, then halt it with half=0.
    sync = 1'b1; wr_en = 1'b1; wr_ch = 1'b0; wr_data = 8'd3;
    cyc(1);
    sync = 1'b0;
    wr_data = 8'd0;
    cyc(1);
    wr_en = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      if (!pending[0]) found = 1;
    end
    chk("zero half applied", int'(found), 1);
    cyc(1);
    a = clock_out[0];
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("zero half tick0", int'(tick[0]), 0);
    end
    chk("zero half holds", int'(clock_out[0]), int'(a));

    // Mid-count asynchronous reset.
    sync = 1'b1; wr_en = 1'b1; wr_ch = 1'b0; wr_data = 8'd3;
    cyc(1);
    sync = 1'b0; wr_en = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(1);
      if (clock_out[0]) found = 1;
    end
    chk("pre-reset out0 high", int'(found), 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async reset clock_out", int'(clock_out), 0);
    chk("async reset tick",      int'(tick),      0);
    chk("async reset pending",   int'(pending),   0);
    cyc(2);
    reset = 1'b0;
    check_basic();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
